bcd_seg_scan_driver: RTL

BCD_SEG_SCAN_DRIVER -- requirements
Module: bcd_seg_scan_driver

---
 rtl/seg_pkg.sv | 22 ++
 rtl/bcd_to_seg.sv | 30 +++
 rtl/bcd_seg_scan_driver.sv | 83 ++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Segment code constants (active-low, seg[6:0] = g,f,e,d,c,b,a) and the BCD
// digit type shared by the scan driver and its decoder.
package seg_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] AN_OFF    = 4'hF;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD to seven-segment decoder; codes 10..15 show a dash.
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    bcd_digit_t code;

    assign code = digit;

    always_comb begin
        seg = SEG_DASH;
        case (code)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver with registered an/seg outputs.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bcd_in,
    input  logic        load,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    localparam int unsigned PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;
    logic [1:0]    idx;
    logic [15:0]   disp;
    bcd_digit_t    sel_digit;
    logic [6:0]    dec_seg;
    logic          blank;

    assign tick = (presc == LAST);

    always_comb begin
        sel_digit = disp[3:0];
        case (idx)
            2'd1:    sel_digit = disp[7:4];
            2'd2:    sel_digit = disp[11:8];
            2'd3:    sel_digit = disp[15:12];
            default: sel_digit = disp[3:0];
        endcase
    end

    bcd_to_seg u_dec (
        .digit (sel_digit),
        .seg   (dec_seg)
    );

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more significant digit are zero.
    always_comb begin
        blank = 1'b0;
        case (idx)
            2'd3:    blank = (disp[15:12] == 4'h0);
            2'd2:    blank = (disp[15:8]  == 8'h00);
            2'd1:    blank = (disp[15:4]  == 12'h000);
            default: blank = 1'b0;
        endcase
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    // Load never disturbs the prescaler or index, so the scan phase is data-independent.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc <= '0;
            idx   <= '0;
            disp  <= '0;
            an    <= AN_OFF;
            seg   <= SEG_BLANK;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick) begin
                idx <= idx + 2'd1;
            end
            if (load) begin
                disp <= bcd_in;
            end
            an  <= ~(4'b0001 << idx);
            seg <= blank ? SEG_BLANK : dec_seg;
        end
    end

endmodule
